addressing_mode: RTL and testbench
==================================

Name: addressing_mode

Overview:
- RV32I instruction-class decoder for the multi-cycle `cpu` core.
- Maps the 7-bit opcode combinationally to a 4-bit mode code; the core's DECODE state branches on this code.
- Also provides a one-cycle registered decode bundle: mode, register fields, funct fields, and the sign-extended immediate, so later core revisions can use pre-decoded operands.

Parameters:
- XLEN, 32, instruction/immediate width (only 32 supported).

Ports:
- clk  in  1  clock, all registered outputs update on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  instr[6:0], drives combinational mode
- instr  in  32  full instruction word for registered decode
- instr_valid  in  1  capture enable for registered decode
- mode  out  4  combinational class code from opcode
- mode_q  out  4  registered class code from instr[6:0]
- imm_q  out  32  registered sign-extended immediate
- rd_q  out  5  registered instr[11:7]
- rs1_q  out  5  registered instr[19:15]
- rs2_q  out  5  registered instr[24:20]
- funct3_q  out  3  registered instr[14:12]
- funct7_q  out  7  registered instr[31:25]
- illegal_q  out  1  registered: class code is 0
- valid_q  out  1  registered instr_valid

Behaviour:
Mode encoding (same table for mode and mode_q; exact 7-bit match required):
- 0110011 R-ALU -> 1
- 0010011 I-ALU -> 2
- 0000011 LOAD -> 3
- 0100011 STORE -> 4
- 1100011 BRANCH -> 5
- 1101111 JAL -> 6
- 0110111 LUI -> 7
- 0010111 AUIPC -> 8
- 1110011 SYSTEM -> 9 (core treats it as halt: PC returns to 0)
- 1100111 JALR -> 10
- any other opcode, including FENCE and opcode[1:0]!=11 -> 0
- codes 11-15 are never produced.

Combinational path:
- mode is purely combinational from opcode, with no dependence on clk or rst.
- The same-cycle value is valid; the core samples it in DECODE.

Registered path (1-cycle latency):
- On rising clk with rst=1: every _q output becomes 0, and valid_q becomes 0.
- Otherwise, valid_q <= instr_valid every cycle.
- If instr_valid=1, all other _q outputs capture decode of instr.
- If instr_valid=0, all other _q outputs hold their previous values.
- rst has priority over instr_valid.
- Field outputs are raw bit slices regardless of class; unused fields are not zeroed.
- illegal_q = (decoded class == 0).

imm_q by class (sign bit is always instr[31]):
- I-ALU, LOAD, JALR, SYSTEM: sext(instr[31:20]).
- STORE: sext({instr[31:25], instr[11:7]}).
- BRANCH: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
- JAL: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
- LUI, AUIPC: {instr[31:12], 12'h000}.
- R-ALU and class 0: 32'h0.

Other rules:
- No internal state beyond the capture registers; there is no handshake and no stall.
- Back-to-back captures every cycle are supported.
- Reset asserted mid-stream clears outputs on that edge.
- The first capture after reset deassert occurs on the following edge if instr_valid=1.

Test Plan:
- Sweep all 128 opcode values -> mode matches the table; e.g. 0x33->1, 0x13->2, 0x6F->6, 0x67->10, 0x73->9, 0x0F->0, 0x00->0.
- instr=0xFFF00093 (addi x1,x0,-1), instr_valid=1, one edge -> mode_q=2, imm_q=0xFFFFFFFF, rd_q=1, rs1_q=0, funct3_q=0, illegal_q=0, valid_q=1.
- instr=0xFE209EE3 (bne x1,x2,-4) -> mode_q=5, imm_q=0xFFFFFFFC, rs1_q=1, rs2_q=2, funct3_q=1.
- instr=0x00C0006F (jal x0,+12) -> mode_q=6, imm_q=0x0000000C; then instr=0x123452B7 (lui x5,0x12345) -> mode_q=7, imm_q=0x12345000, rd_q=5.
- Capture store 0x00112423 (sw x1,8(x2)) -> imm_q=8, mode_q=4. Then instr_valid=0 with a new instr -> _q outputs hold and valid_q=0. Then assert rst -> all _q outputs 0 on the next edge.
- Capture instr=0x0000000B -> mode_q=0, illegal_q=1, imm_q=0.

Source files
------------

// File: rtl/addressing_mode.sv
// addressing_mode: RV32I opcode class decoder with a one-cycle registered decode bundle
module addressing_mode #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [6:0]      opcode,
    input  logic [XLEN-1:0] instr,
    input  logic            instr_valid,
    output logic [3:0]      mode,
    output logic [3:0]      mode_q,
    output logic [XLEN-1:0] imm_q,
    output logic [4:0]      rd_q,
    output logic [4:0]      rs1_q,
    output logic [4:0]      rs2_q,
    output logic [2:0]      funct3_q,
    output logic [6:0]      funct7_q,
    output logic            illegal_q,
    output logic            valid_q
);
    function automatic logic [3:0] classify(input logic [6:0] op);
        return op == 7'b0110011 ? 4'd1  :
               op == 7'b0010011 ? 4'd2  :
               op == 7'b0000011 ? 4'd3  :
               op == 7'b0100011 ? 4'd4  :
               op == 7'b1100011 ? 4'd5  :
               op == 7'b1101111 ? 4'd6  :
               op == 7'b0110111 ? 4'd7  :
               op == 7'b0010111 ? 4'd8  :
               op == 7'b1110011 ? 4'd9  :
               op == 7'b1100111 ? 4'd10 : 4'd0;
    endfunction

    logic [3:0]      mode_d;
    logic [XLEN-1:0] imm_d;
    logic            s;

    assign mode   = classify(opcode);
    assign mode_d = classify(instr[6:0]);
    assign s      = instr[31];

    always_comb begin
        imm_d = (mode_d == 4'd2 || mode_d == 4'd3 || mode_d == 4'd9 || mode_d == 4'd10) ?
                    {{(XLEN-12){s}}, instr[31:20]} :
                mode_d == 4'd4 ? {{(XLEN-12){s}}, instr[31:25], instr[11:7]} :
                mode_d == 4'd5 ? {{(XLEN-13){s}}, s, instr[7], instr[30:25], instr[11:8], 1'b0} :
                mode_d == 4'd6 ? {{(XLEN-21){s}}, s, instr[19:12], instr[20], instr[30:21], 1'b0} :
                (mode_d == 4'd7 || mode_d == 4'd8) ? {instr[31:12], 12'h000} :
                '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= '0;
            imm_q     <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            funct3_q  <= '0;
            funct7_q  <= '0;
            illegal_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= instr_valid;
            if (instr_valid) begin
                mode_q    <= mode_d;
                imm_q     <= imm_d;
                rd_q      <= instr[11:7];
                rs1_q     <= instr[19:15];
                rs2_q     <= instr[24:20];
                funct3_q  <= instr[14:12];
                funct7_q  <= instr[31:25];
                illegal_q <= mode_d == 4'd0;
            end
        end
    end
endmodule

// File: tb/tb_addressing_mode.sv
// tb_addressing_mode: random and directed checks of addressing_mode against a table-driven model
module tb_addressing_mode;
    logic        clk = 0;
    logic        rst = 1;
    logic [6:0]  opcode = '0;
    logic [31:0] instr = '0;
    logic        instr_valid = 0;
    logic [3:0]  mode, mode_q;
    logic [31:0] imm_q;
    logic [4:0]  rd_q, rs1_q, rs2_q;
    logic [2:0]  funct3_q;
    logic [6:0]  funct7_q;
    logic        illegal_q, valid_q;

    int total = 0;
    int bad = 0;

    logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h73, 7'h67};
    logic [3:0]  e_mode = 0;
    logic [31:0] e_imm = 0, e_ins = 0;
    logic        e_ill = 0, e_valid = 0;

    addressing_mode #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .instr(instr), .instr_valid(instr_valid),
        .mode(mode), .mode_q(mode_q), .imm_q(imm_q), .rd_q(rd_q), .rs1_q(rs1_q),
        .rs2_q(rs2_q), .funct3_q(funct3_q), .funct7_q(funct7_q), .illegal_q(illegal_q),
        .valid_q(valid_q)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] ref_mode(input logic [6:0] op);
        for (int k = 0; k < 10; k++)
            if (ops[k] == op) return 4'(k + 1);
        return 4'd0;
    endfunction

    // immediate rebuilt with arithmetic shifts on the signed word
    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        int sw;
        int c;
        sw = int'(w);
        c = int'(ref_mode(w[6:0]));
        case (c)
            2, 3, 9, 10: return 32'(sw >>> 20);
            4: return 32'(((sw >>> 25) <<< 5) | int'(w[11:7]));
            5: return 32'(((sw >>> 31) <<< 12) | (int'(w[7]) << 11) | (int'(w[30:25]) << 5) | (int'(w[11:8]) << 1));
            6: return 32'(((sw >>> 31) <<< 20) | (int'(w[19:12]) << 12) | (int'(w[20]) << 11) | (int'(w[30:21]) << 1));
            7, 8: return w & 32'hFFFFF000;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("mode", 32'(mode), 32'(ref_mode(opcode)));
        chk("mode_q", 32'(mode_q), 32'(e_mode));
        chk("imm_q", imm_q, e_imm);
        chk("rd_q", 32'(rd_q), 32'(e_ins[11:7]));
        chk("rs1_q", 32'(rs1_q), 32'(e_ins[19:15]));
        chk("rs2_q", 32'(rs2_q), 32'(e_ins[24:20]));
        chk("funct3_q", 32'(funct3_q), 32'(e_ins[14:12]));
        chk("funct7_q", 32'(funct7_q), 32'(e_ins[31:25]));
        chk("illegal_q", 32'(illegal_q), 32'(e_ill));
        chk("valid_q", 32'(valid_q), 32'(e_valid));
    endtask

    task automatic step(input logic r, input logic v, input logic [31:0] w);
        rst = r;
        instr_valid = v;
        instr = w;
        opcode = w[6:0];
        @(posedge clk);
        if (r) begin
            e_mode = 0; e_imm = 0; e_ins = 0; e_ill = 0; e_valid = 0;
        end else begin
            e_valid = v;
            if (v) begin
                e_mode = ref_mode(w[6:0]);
                e_imm = ref_imm(w);
                e_ins = w;
                e_ill = (e_mode == 0);
            end
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [31:0] w;
        @(negedge clk);
        step(1, 1, 32'hFFF00093);
        chk("rst_valid_q", 32'(valid_q), 0);
        for (int op = 0; op < 128; op++) begin
            opcode = 7'(op);
            #1;
            chk("sweep_mode", 32'(mode), 32'(ref_mode(7'(op))));
        end
        @(negedge clk);
        step(0, 1, 32'hFFF00093);
        chk("addi_imm", imm_q, 32'hFFFFFFFF);
        chk("addi_mode", 32'(mode_q), 2);
        step(0, 1, 32'hFE209EE3);
        chk("bne_imm", imm_q, 32'hFFFFFFFC);
        chk("bne_mode", 32'(mode_q), 5);
        step(0, 1, 32'h00C0006F);
        chk("jal_imm", imm_q, 32'h0000000C);
        step(0, 1, 32'h123452B7);
        chk("lui_imm", imm_q, 32'h12345000);
        chk("lui_rd", 32'(rd_q), 5);
        step(0, 1, 32'h00112423);
        chk("sw_imm", imm_q, 32'h8);
        chk("sw_mode", 32'(mode_q), 4);
        step(0, 0, 32'hFFF00093);
        chk("hold_imm", imm_q, 32'h8);
        chk("hold_valid", 32'(valid_q), 0);
        step(1, 1, 32'hFFF00093);
        chk("rst_imm", imm_q, 0);
        step(0, 1, 32'h0000000B);
        chk("ill_q", 32'(illegal_q), 1);
        chk("ill_mode", 32'(mode_q), 0);
        for (int n = 0; n < 600; n++) begin
            w = $urandom;
            if ($urandom_range(0, 4) != 0) w[6:0] = ops[$urandom_range(0, 9)];
            step($urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)), w);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
